// File: rtl/des_round_ctrl.sv
// -----------------------------------------------------------------------------
// des_round_ctrl
//
// Iterative 16-round DES Feistel controller. It sits between the initial
// permutation and the final permutation. One round is executed per clock. The
// f-function and PC-2 are external: this block drives the current R half and
// the current-round CD key state to des_f, and takes f_out back in the same
// cycle. After round 16 it presents the swapped R16||L16 word on preoutput.
//
// Bit numbering: vector index i corresponds to DES bit i+1.
//
// Ports
//   clk        in   1   rising-edge clock
//   rst        in   1   synchronous, active-high reset
//   start      in   1   block request, sampled only while idle
//   decrypt    in   1   sampled with start; selects the reverse key schedule
//   data_in    in  64   IP output: [31:0]=L0, [63:32]=R0
//   cd_in      in  56   PC-1 output: [27:0]=C0, [55:28]=D0
//   f_out      in  32   f(round_r, PC-2(round_cd)), combinational from des_f
//   round_r    out 32   current R register
//   round_cd   out 56   current-round CD register
//   busy       out  1   rounds in progress
//   done       out  1   one-cycle pulse when preoutput updates
//   preoutput  out 64   [31:0]=R16, [63:32]=L16; held until next completion
// -----------------------------------------------------------------------------
module des_round_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        decrypt,
    input  logic [63:0] data_in,
    input  logic [55:0] cd_in,
    input  logic [31:0] f_out,
    output logic [31:0] round_r,
    output logic [55:0] round_cd,
    output logic        busy,
    output logic        done,
    output logic [63:0] preoutput
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [31:0] l_reg;
    logic [31:0] r_reg;
    logic [55:0] cd_reg;
    logic [55:0] cd_next;
    logic [3:0]  cnt;
    logic        mode;        // 1 = decrypt, captured on accept
    logic        accept;
    logic        last_round;
    logic        one_shift;
    logic [31:0] r_new;

    // Rotate one 28-bit key half by one or two places. Left is the DES
    // encrypt direction (new[i] = old[i+1]); right is the decrypt direction.
    function automatic logic [27:0] rot_half(input logic [27:0] h,
                                             input logic        left,
                                             input logic        two);
        logic [27:0] r;
        case ({left, two})
            2'b10:   r = {h[0],    h[27:1]};
            2'b11:   r = {h[1:0],  h[27:2]};
            2'b00:   r = {h[26:0], h[27]};
            default: r = {h[25:0], h[27:26]};
        endcase
        return r;
    endfunction

    // C and D halves rotate independently.
    function automatic logic [55:0] rot_cd(input logic [55:0] cd,
                                           input logic        left,
                                           input logic        two);
        return {rot_half(cd[55:28], left, two), rot_half(cd[27:0], left, two)};
    endfunction

    assign accept     = (state == IDLE) && start;
    assign last_round = (state == RUN) && (cnt == 4'd15);
    assign r_new      = l_reg ^ f_out;

    // The RUN edge at counter value c prepares the key for round c+2. Both
    // directions shift by one for rounds 2, 9 and 16 and by two otherwise;
    // they differ only in direction and in the round-1 pre-rotation.
    assign one_shift  = (cnt == 4'd0) || (cnt == 4'd7) || (cnt == 4'd14);

    // ---------------------------------------------------------------- FSM
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (cnt == 4'd15) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------ key schedule
    always_comb begin
        cd_next = cd_reg;
        if (accept) begin
            // Round 1: encrypt rotates left once, decrypt uses C0D0 as is.
            cd_next = decrypt ? cd_in : rot_cd(cd_in, 1'b1, 1'b0);
        end else if (state == RUN) begin
            cd_next = rot_cd(cd_reg, ~mode, ~one_shift);
        end
    end

    // ---------------------------------------------------------- datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            l_reg     <= '0;
            r_reg     <= '0;
            cd_reg    <= '0;
            cnt       <= '0;
            mode      <= 1'b0;
            preoutput <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                l_reg  <= data_in[31:0];
                r_reg  <= data_in[63:32];
                cnt    <= '0;
                mode   <= decrypt;
                cd_reg <= cd_next;
            end else if (state == RUN) begin
                l_reg  <= r_reg;
                r_reg  <= r_new;
                cnt    <= cnt + 4'd1;
                cd_reg <= cd_next;
                if (last_round) begin
                    // Final swap: R16 goes low, L16 (= R15) goes high.
                    preoutput <= {r_reg, r_new};
                    done      <= 1'b1;
                end
            end
        end
    end

    assign busy     = (state == RUN);
    assign round_r  = r_reg;
    assign round_cd = cd_reg;

endmodule

// File: doc/des_round_ctrl.md
# des_round_ctrl

Iterative 16-round Feistel controller for the DES datapath. It sits directly upstream of the final permutation. It takes the initial-permutation output and the PC-1-permuted key, and runs one round per clock. The f-function and PC-2 live in the external combinational `des_f` block. After the last round it presents the swapped R16‖L16 word on `preoutput`, the input the final permutation expects.

## Interface
Bit numbering throughout: vector index i = DES bit i+1, so index 0 is DES bit 1.
- No parameters. Round count is fixed at 16.
- Reset: one clock; reset is synchronous and active-high.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only when `busy`=0.
- `decrypt`  in  1  sampled with `start`; 1 selects the reverse key schedule.
- `data_in`  in  64  IP output; `[31:0]`=L0, `[63:32]`=R0.
- `cd_in`  in  56  PC-1 output; `[27:0]`=C0, `[55:28]`=D0.
- `f_out`  in  32  f(`round_r`, PC-2(`round_cd`)); combinational, valid in the same cycle.
- `round_r`  out  32  current R register, driven to `des_f`.
- `round_cd`  out  56  current-round CD register, driven to `des_f` (PC-2 applied there).
- `busy`  out  1  high while rounds are in progress.
- `done`  out  1  one-cycle pulse when `preoutput` updates.
- `preoutput`  out  64  `[31:0]`=R16, `[63:32]`=L16; held until the next completion.

## Operation
- State machine has two states: IDLE and RUN. `busy` = (state==RUN).
- Accept: in IDLE with `start`=1 at a clock edge:
  - L←`data_in[31:0]`, R←`data_in[63:32]`, round counter←0, mode←`decrypt`, state←RUN.
  - CD←`cd_in` pre-rotated for round 1: encrypt rotates once; decrypt applies no rotation.
- Rotation, per 28-bit half, independently for C and D:
  - Left rotation (DES sense): new[i]=old[(i+1) mod 28].
  - Right rotation: new[i]=old[(i+27) mod 28].
- Shift amounts for rounds 1..16:
  - Encrypt, left: 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
  - Decrypt, right: 0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
- Each RUN edge:
  - L←R, R←L XOR `f_out`, counter+1.
  - CD←CD rotated by the shift for the next round.
- Final round (counter==15):
  - `preoutput[31:0]`←L XOR `f_out` (R16), `preoutput[63:32]`←R (L16).
  - `done`←1, state←IDLE.
  - The CD update on this edge is don't-care.
- `start` while `busy`=1 is ignored and not queued.
- `decrypt`, `data_in` and `cd_in` are only sampled on accept. Changes mid-run have no effect.
- Reset (any state, including mid-run):
  - state←IDLE; L, R, CD, counter, `preoutput`←0; `busy`=0, `done`=0.
  - An aborted run produces no `done`.

## Timing
- Edge E0 samples `start`. Rounds 1..16 occur on edges E1..E16.
- `busy`=1 in the 16 cycles following E0. `done`=1 and new `preoutput` appear in the cycle following E16.
- Latency is 16 cycles from accept to `done`. Throughput is 16 cycles/block.
- `start` asserted during the `done` cycle is accepted (`busy`=0 there), giving back-to-back blocks with no gap.
- `round_r`/`round_cd` for round k are stable for the whole cycle between E(k-1) and Ek. `des_f` must settle within that cycle.
- `done` is a single-cycle pulse; it never stays high for two consecutive cycles.

## Test plan
- Reset: hold `rst` 2 cycles with random inputs -> `busy`=0, `done`=0, `preoutput`=0, `round_r`=0, `round_cd`=0.
- Swap check: `f_out` tied to 0, `data_in`=64'h89ABCDEF_01234567, start -> `done` exactly 16 cycles later, `preoutput`=64'h01234567_89ABCDEF, `busy` high for exactly 16 cycles.
- Key schedule: `f_out`=0, `cd_in`=56'h1:
  - Encrypt -> `round_cd` in round 1 = 56'h0000000_8000000; round 16 = 56'h1.
  - Decrypt -> round 1 = 56'h1; round 2 = 56'h2; round 3 = 56'h8.
- Full vector: bench golden model for IP/PC-1/f/final permutation, key 64'h133457799BBCDFF1, plaintext 64'h0123456789ABCDEF -> ciphertext 64'h85E813540F0AB405. Decrypt of that ciphertext returns 64'h0123456789ABCDEF.
- Handshake:
  - `start` held high throughout a run -> no restart before `done`.
  - `start` in the `done` cycle -> second block accepted, second `done` 16 cycles later, first `preoutput` held until then.
- Mid-run reset: `rst` pulsed after round 8 -> `busy`=0 the next cycle, no `done`, `preoutput`=0. A new start afterwards completes normally.
